// File: rtl/rv_fetch_assembler.sv
// ============================================================================
// rv_fetch_assembler
// ----------------------------------------------------------------------------
// Instruction-fetch front end. Reads 16-bit halfwords from the instruction
// port of the dual-port cache and assembles them into RV32 instructions
// (16-bit compressed or 32-bit). Assembled instructions are handed to decode
// over a valid/ready handshake. The block owns the fetch PC and accepts
// redirects from branch/jump/trap logic.
//
// Build option:
//   RV_FETCH_RVC_EN  defined   -> compressed (16-bit) instructions are detected
//                                 from bits [1:0] of the low halfword.
//                    undefined -> every instruction is 32-bit, the PC is kept
//                                 word aligned and always advances by 4.
//
// Ports:
//   clk                  system clock, rising edge
//   rst_n                asynchronous active-low reset
//   mem_en               cache instruction-port enable
//   mem_addr             halfword byte address to the cache (bit 0 always 0)
//   mem_rdata            halfword from the cache, valid one cycle after mem_en
//   redirect_valid       load a new fetch PC this cycle
//   redirect_pc          redirect target
//   instr_valid          instr/instr_pc/instr_is_compressed hold an instruction
//   instr_ready          decode accepts the instruction
//   instr                assembled instruction (compressed: zero-extended)
//   instr_pc             address of the instruction
//   instr_is_compressed  1 = 16-bit instruction
//
// Handshake: an instruction transfers on every rising clk edge where
// instr_valid and instr_ready are both 1. While instr_valid=1 and
// instr_ready=0 the payload is held stable; instr_valid drops only after a
// transfer or a redirect, never on its own.
//
// Debug visibility: the FSM state is held in state_q (encodings below).
// ============================================================================
module rv_fetch_assembler #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [15:0]           mem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_is_compressed
);

    // FSM encodings
    localparam logic [2:0] S_IDLE   = 3'd0;  // only while in reset
    localparam logic [2:0] S_REQ_LO = 3'd1;  // request low halfword at pc
    localparam logic [2:0] S_LO     = 3'd2;  // low halfword arrives
    localparam logic [2:0] S_HI     = 3'd3;  // high halfword arrives
    localparam logic [2:0] S_OUT    = 3'd4;  // instruction presented to decode

`ifdef RV_FETCH_RVC_EN
    // Halfword-aligned PC.
    localparam logic [ADDR_WIDTH-1:0] PC_MASK = ~(ADDR_WIDTH'(1));
`else
    // Word-aligned PC: the low half always sits at xx00, the high half at xx10.
    localparam logic [ADDR_WIDTH-1:0] PC_MASK = ~(ADDR_WIDTH'(3));
`endif

    logic [2:0]            state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [15:0]           lo_q;
    logic [ADDR_WIDTH-1:0] pc_plus2;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic                  rdata_is_c;

    // Wraps modulo 2^ADDR_WIDTH, so a 32-bit instruction in the top halfword
    // takes its high half from address 0.
    assign pc_plus2 = pc_q + ADDR_WIDTH'(2);
    assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

`ifdef RV_FETCH_RVC_EN
    assign rdata_is_c = (mem_rdata[1:0] != 2'b11);
`else
    assign rdata_is_c = 1'b0;
`endif

    // Cache request. In LO the high-half request is issued in the same cycle
    // the low half is seen, which is what gives the 3-cycle 32-bit latency.
    always_comb begin
        mem_en   = 1'b0;
        mem_addr = pc_q;
        case (state_q)
            S_REQ_LO: begin
                mem_en   = 1'b1;
                mem_addr = pc_q;
            end
            S_LO: begin
                if (!rdata_is_c) begin
                    mem_en   = 1'b1;
                    mem_addr = pc_plus2;
                end
            end
            default: begin
                mem_en   = 1'b0;
                mem_addr = pc_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= S_IDLE;
            pc_q                <= RESET_PC & PC_MASK;
            lo_q                <= 16'h0000;
            instr_valid         <= 1'b0;
            instr               <= 32'h0000_0000;
            instr_pc            <= '0;
            instr_is_compressed <= 1'b0;
        end else if (redirect_valid && (state_q != S_IDLE)) begin
            // Redirect beats everything: drops any half-built instruction and
            // any halfword in flight. If it lands on an OUT transfer, decode
            // has already taken the instruction; only the next PC changes.
            pc_q        <= redirect_pc & PC_MASK;
            instr_valid <= 1'b0;
            state_q     <= S_REQ_LO;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ_LO;
                end
                S_REQ_LO: begin
                    state_q <= S_LO;
                end
                S_LO: begin
                    if (rdata_is_c) begin
                        instr               <= {16'h0000, mem_rdata};
                        instr_is_compressed <= 1'b1;
                        instr_pc            <= pc_q;
                        instr_valid         <= 1'b1;
                        state_q             <= S_OUT;
                    end else begin
                        lo_q    <= mem_rdata;
                        state_q <= S_HI;
                    end
                end
                S_HI: begin
                    instr               <= {mem_rdata, lo_q};
                    instr_is_compressed <= 1'b0;
                    instr_pc            <= pc_q;
                    instr_valid         <= 1'b1;
                    state_q             <= S_OUT;
                end
                S_OUT: begin
                    if (instr_ready) begin
                        pc_q        <= instr_is_compressed ? pc_plus2 : pc_plus4;
                        instr_valid <= 1'b0;
                        state_q     <= S_REQ_LO;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rv_fetch_assembler.md
Name: rv_fetch_assembler

Overview:
Instruction-fetch front end that drives the instruction port of the dual-port cache. It consumes 16-bit halfwords from that port and assembles them into complete RV32 instructions, either 16-bit compressed or 32-bit. Assembled instructions go to the decode stage through a valid/ready handshake. It owns the fetch PC and accepts redirects from branch/jump/trap logic.

Parameters:
ADDR_WIDTH, 16, byte-address width of the fetch PC and of the cache port.
RESET_PC, 0, fetch address loaded on reset; bit 0 is ignored.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
mem_en  output  1  cache instruction-port enable (to ena).
mem_addr  output  ADDR_WIDTH  halfword byte address (to addra); bit 0 is always 0.
mem_rdata  input  16  halfword returned by the cache one cycle after mem_en.
redirect_valid  input  1  load a new fetch PC this cycle.
redirect_pc  input  ADDR_WIDTH  redirect target.
instr_valid  output  1  instr/instr_pc hold a complete instruction.
instr_ready  input  1  decode accepts the instruction.
instr  output  32  assembled instruction; compressed instructions are zero-extended in [15:0].
instr_pc  output  ADDR_WIDTH  address of the instruction.
instr_is_compressed  output  1  1 = 16-bit instruction.

Behaviour:
- Cache timing: address is presented with mem_en in cycle N; mem_rdata is valid in cycle N+1 only. The block does not rely on mem_rdata holding after that cycle.
- mem_en and mem_addr are combinational from state and pc. All other outputs are registered.
- States:
  - IDLE: entered only during reset. mem_en=0. Moves to REQ_LO unconditionally on the first clock after reset deasserts.
  - REQ_LO: mem_en=1, mem_addr=pc. Next state is LO.
  - LO: captures mem_rdata as the low half.
    - If mem_rdata[1:0]!=2'b11 (compressed): instr<={16'h0,mem_rdata}, instr_is_compressed<=1, instr_pc<=pc, go to OUT.
    - Otherwise: latch the low half, drive mem_en=1 and mem_addr=pc+2 in this same cycle, go to HI.
  - HI: instr<={mem_rdata,low}, instr_is_compressed<=0, instr_pc<=pc, go to OUT.
  - OUT: instr_valid=1. instr, instr_pc and instr_is_compressed are held stable while instr_ready=0. On instr_ready=1: pc<=pc+2 (compressed) or pc+4, instr_valid<=0, go to REQ_LO.
- Latency from REQ_LO to instr_valid: 2 cycles for a compressed instruction, 3 cycles for a 32-bit instruction. Sustained throughput is one instruction per 3 or 4 cycles; there is no prefetch.
- PC arithmetic is modulo 2^ADDR_WIDTH. A 32-bit instruction at the top halfword takes its high half from address 0.
- Redirect:
  - Highest priority, accepted in any state except IDLE.
  - pc<={redirect_pc[ADDR_WIDTH-1:1],1'b0}. Any partially assembled or in-flight halfword is discarded. instr_valid<=0. Next state is REQ_LO.
  - If the redirect coincides with an OUT handshake, the handshake completes (decode keeps the instruction) and the redirect PC wins over pc+2/4.
  - A redirect in LO or HI suppresses that cycle's capture.
- Reset (asynchronous, any time, including mid-assembly): state=IDLE, pc=RESET_PC with bit 0 cleared, instr_valid=0, instr=0, instr_pc=0, instr_is_compressed=0, mem_en=0.
- instr_valid never toggles without a handshake or a redirect.

Optional Feature:
Macro RV_FETCH_RVC_EN.
- Defined: compressed detection as above.
- Undefined:
  - Every instruction is 32-bit. LO always issues the high-half fetch.
  - instr_is_compressed is tied 0 and pc always advances by 4.
  - Redirect and reset clear pc[1:0].
  - mem_addr[1:0] is 2'b00 for the low half and 2'b10 for the high half.

Test Plan:
1. Reset release with RESET_PC=0, mem[0..3]=13 05 00 00 (addi x10,x0,0): instr_valid rises 3 cycles after leaving IDLE, instr=32'h00000513, instr_pc=0, compressed=0; with instr_ready=1 the next fetch is at 0x0004.
2. Compressed: halfword 16'h4501 at 0x0004 -> instr=32'h00004501, compressed=1, valid 2 cycles after REQ_LO; next pc=0x0006.
3. Backpressure: hold instr_ready=0 for 5 cycles in OUT -> instr/instr_pc stable and mem_en=0 throughout; advance occurs only on the ready cycle.
4. Redirect to 0x0101 while in HI -> partial instruction dropped, next mem_addr=0x0100, instr_valid stays 0 until the new instruction completes; redirect on the same cycle as a handshake -> instruction consumed, next fetch at the redirect target.
5. Wrap: 32-bit instruction at 0xFFFE with halves 16'h0513/16'h0000 -> mem_addr sequence 0xFFFE then 0x0000, instr=32'h00000513, next pc=0x0002.
6. Assert rst_n=0 mid-HI -> outputs clear immediately (asynchronously); after release, fetch restarts at RESET_PC.
